// File: rtl/counter4_pkg.sv
//----------------------------------------------------------------------------
// Module   : counter4_pkg
// Brief    : Shared mode, state and limit definitions for 4-bit counter blocks.
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

package counter4_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [0:0] {
    SYNC = 1'b0,
    LOST = 1'b1
  } mon_state_t;

  localparam logic [1:0] LOST_THRESHOLD = 2'd3;
  localparam logic [7:0] ERRCNT_MAX     = 8'd255;

endpackage

`default_nettype wire

// File: rtl/counter4_model.sv
//----------------------------------------------------------------------------
// Module   : counter4_model
// Brief    : Combinational next-count function of the 4-bit up/down/load counter.
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module counter4_model
  import counter4_pkg::*;
(
  input  logic [1:0] i_mode,
  input  logic [3:0] i_din,
  input  logic [3:0] i_cur,
  output logic [3:0] o_next
);

  // Up and down wrap naturally in 4-bit arithmetic.
  always_comb begin
    o_next = i_cur;
    case (i_mode)
      MODE_HOLD: o_next = i_cur;
      MODE_UP:   o_next = i_cur + 4'd1;
      MODE_DOWN: o_next = i_cur - 4'd1;
      MODE_LOAD: o_next = i_din;
      default:   o_next = i_cur;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/counter4_monitor.sv
//----------------------------------------------------------------------------
// Module   : counter4_monitor
// Brief    : Shadow-count checker for a 4-bit counter; optional first-error
//            capture enabled by defining COUNTER4_MONITOR_CAPTURE_EN.
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module counter4_monitor
  import counter4_pkg::*;
(
  input  logic        Ck,
  input  logic        Reset,
  input  logic [1:0]  Mode,
  input  logic [3:0]  Din,
  input  logic [3:0]  Out,
  output logic [3:0]  Expect,
  output logic        Mismatch,
  output logic        Lost,
  output logic [7:0]  ErrCount,
  output logic [15:0] FirstErrCycle,
  output logic [3:0]  FirstErrExp,
  output logic [3:0]  FirstErrAct,
  output logic        Captured
);

  mon_state_t r_state;
  logic [3:0] r_expect;
  logic       r_mismatch;
  logic [7:0] r_errcount;
  logic [1:0] r_miss;

  logic [3:0] w_next;
  logic       w_fail;
  logic       w_load;
  logic [1:0] w_miss_next;

  counter4_model u_model (
    .i_mode (Mode),
    .i_din  (Din),
    .i_cur  (r_expect),
    .o_next (w_next)
  );

  assign w_fail      = (r_state == SYNC) && (Out != r_expect);
  assign w_load      = (Mode == MODE_LOAD);
  assign w_miss_next = w_fail ? (r_miss + 2'd1) : 2'd0;

  always_ff @(posedge Ck) begin
    if (!Reset) begin
      r_state    <= SYNC;
      r_expect   <= 4'd0;
      r_mismatch <= 1'b0;
      r_errcount <= 8'd0;
      r_miss     <= 2'd0;
    end else begin
      case (r_state)
        SYNC: begin
          r_mismatch <= w_fail;
          if (w_fail && (r_errcount != ERRCNT_MAX))
            r_errcount <= r_errcount + 8'd1;
          r_expect <= w_next;
          // A load resynchronises the shadow, so it outranks the lost transition.
          if (w_load) begin
            r_miss <= 2'd0;
          end else if (w_miss_next == LOST_THRESHOLD) begin
            r_miss  <= 2'd0;
            r_state <= LOST;
          end else begin
            r_miss <= w_miss_next;
          end
        end
        default: begin
          r_mismatch <= 1'b0;
          if (w_load) begin
            r_expect <= Din;
            r_miss   <= 2'd0;
            r_state  <= SYNC;
          end
        end
      endcase
    end
  end

  assign Expect   = r_expect;
  assign Mismatch = r_mismatch;
  assign Lost     = (r_state == LOST);
  assign ErrCount = r_errcount;

`ifdef COUNTER4_MONITOR_CAPTURE_EN
  logic [15:0] r_cycle;
  logic [15:0] r_first_cycle;
  logic [3:0]  r_first_exp;
  logic [3:0]  r_first_act;
  logic        r_captured;

  always_ff @(posedge Ck) begin
    if (!Reset) begin
      r_cycle       <= 16'd0;
      r_first_cycle <= 16'd0;
      r_first_exp   <= 4'd0;
      r_first_act   <= 4'd0;
      r_captured    <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 16'd1;
      if (w_fail && !r_captured) begin
        r_first_cycle <= r_cycle;
        r_first_exp   <= r_expect;
        r_first_act   <= Out;
        r_captured    <= 1'b1;
      end
    end
  end

  assign FirstErrCycle = r_first_cycle;
  assign FirstErrExp   = r_first_exp;
  assign FirstErrAct   = r_first_act;
  assign Captured      = r_captured;
`else
  assign FirstErrCycle = 16'd0;
  assign FirstErrExp   = 4'd0;
  assign FirstErrAct   = 4'd0;
  assign Captured      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_counter4_monitor.sv
//----------------------------------------------------------------------------
// Module   : tb_counter4_monitor
// Brief    : Self-checking bench for counter4_monitor against a behavioural model.
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_counter4_monitor;

`ifdef COUNTER4_MONITOR_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic        Ck = 1'b0;
  logic        Reset = 1'b0;
  logic [1:0]  Mode = 2'b00;
  logic [3:0]  Din = 4'd0;
  logic [3:0]  Out = 4'd0;
  logic [3:0]  Expect;
  logic        Mismatch;
  logic        Lost;
  logic [7:0]  ErrCount;
  logic [15:0] FirstErrCycle;
  logic [3:0]  FirstErrExp;
  logic [3:0]  FirstErrAct;
  logic        Captured;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int  m_exp, m_err, m_miss, m_cycle, m_fcyc, m_fexp, m_fact;
  bit  m_lost, m_mm, m_capt;

  counter4_monitor dut (
    .Ck(Ck), .Reset(Reset), .Mode(Mode), .Din(Din), .Out(Out),
    .Expect(Expect), .Mismatch(Mismatch), .Lost(Lost), .ErrCount(ErrCount),
    .FirstErrCycle(FirstErrCycle), .FirstErrExp(FirstErrExp),
    .FirstErrAct(FirstErrAct), .Captured(Captured)
  );

  always #5 Ck = ~Ck;

  task automatic model_edge(input bit rst_n, input int m, input int d, input int o);
    bit fail;
    if (!rst_n) begin
      m_exp = 0; m_err = 0; m_miss = 0; m_cycle = 0; m_lost = 0; m_mm = 0;
      m_fcyc = 0; m_fexp = 0; m_fact = 0; m_capt = 0;
      return;
    end
    if (!m_lost) begin
      fail = (o != m_exp);
      m_mm = fail;
      if (fail) begin
        if (m_err < 255) m_err = m_err + 1;
        m_miss = m_miss + 1;
        if (CAP && !m_capt) begin
          m_capt = 1; m_fcyc = m_cycle; m_fexp = m_exp; m_fact = o;
        end
      end else begin
        m_miss = 0;
      end
      case (m)
        1: m_exp = (m_exp + 1) % 16;
        2: m_exp = (m_exp + 15) % 16;
        3: m_exp = d;
        default: ;
      endcase
      if (m == 3) m_miss = 0;
      else if (m_miss >= 3) begin m_lost = 1; m_miss = 0; end
    end else begin
      m_mm = 0;
      if (m == 3) begin m_exp = d; m_lost = 0; m_miss = 0; end
    end
    m_cycle = (m_cycle + 1) % 65536;
  endtask

  task automatic drive_edge(input logic [1:0] m, input logic [3:0] d, input logic [3:0] o);
    Mode = m; Din = d; Out = o;
    @(posedge Ck);
    model_edge(Reset, int'(m), int'(d), int'(o));
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    drive_edge(2'b00, 4'd0, 4'd0);
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_edge(2'(i + 1), 4'd9, 4'd7);
      n_checks++;
      if ({Expect, Mismatch, Lost, ErrCount} !== 15'd0) begin
        n_errors++;
        $display("FAIL reset_core exp=%0d mm=%0b lost=%0b err=%0d required all 0", Expect, Mismatch, Lost, ErrCount);
      end
      n_checks++;
      if ({FirstErrCycle, FirstErrExp, FirstErrAct, Captured} !== 25'd0) begin
        n_errors++;
        $display("FAIL reset_capture cyc=%0d exp=%0d act=%0d capt=%0b required all 0",
                 FirstErrCycle, FirstErrExp, FirstErrAct, Captured);
      end
    end
    Reset = 1'b1;
  endtask

  task automatic test_count_up();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_edge(2'b01, 4'd0, 4'(i));
      n_checks++;
      if (Mismatch !== 1'b0) begin
        n_errors++;
        $display("FAIL up_mismatch step=%0d actual=%0b required=0", i, Mismatch);
      end
    end
    n_checks++;
    if (Expect !== 4'd5) begin
      n_errors++;
      $display("FAIL up_expect actual=%0d required=5", Expect);
    end
  endtask

  task automatic test_wrap();
    int want [4] = '{14, 15, 0, 1};
    do_reset();
    drive_edge(2'b11, 4'd14, 4'd0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (Expect !== 4'(want[i]) || Mismatch !== 1'b0) begin
        n_errors++;
        $display("FAIL wrap_up step=%0d expect=%0d mm=%0b required=%0d/0", i, Expect, Mismatch, want[i]);
      end
      if (i < 3) drive_edge(2'b01, 4'd0, 4'(want[i]));
    end
    drive_edge(2'b10, 4'd0, 4'd1);
    drive_edge(2'b10, 4'd0, 4'd0);
    n_checks++;
    if (Expect !== 4'd15 || Mismatch !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap_down expect=%0d mm=%0b required=15/0", Expect, Mismatch);
    end
  endtask

  task automatic test_single_miss();
    do_reset();
    drive_edge(2'b11, 4'd6, 4'd0);
    drive_edge(2'b00, 4'd0, 4'd9);
    n_checks++;
    if (Mismatch !== 1'b1 || ErrCount !== 8'd1 || Lost !== 1'b0) begin
      n_errors++;
      $display("FAIL miss_pulse mm=%0b err=%0d lost=%0b required=1/1/0", Mismatch, ErrCount, Lost);
    end
    n_checks++;
    if (FirstErrExp !== 4'(CAP ? 6 : 0) || FirstErrAct !== 4'(CAP ? 9 : 0) ||
        Captured !== CAP || FirstErrCycle !== 16'(CAP ? 1 : 0)) begin
      n_errors++;
      $display("FAIL miss_capture exp=%0d act=%0d capt=%0b cyc=%0d required cap=%0b", FirstErrExp, FirstErrAct, Captured, FirstErrCycle, CAP);
    end
    drive_edge(2'b00, 4'd0, 4'd6);
    n_checks++;
    if (Mismatch !== 1'b0 || ErrCount !== 8'd1) begin
      n_errors++;
      $display("FAIL miss_one_cycle mm=%0b err=%0d required=0/1", Mismatch, ErrCount);
    end
  endtask

  task automatic test_lost();
    do_reset();
    for (int i = 0; i < 3; i++) drive_edge(2'b00, 4'd0, 4'd5);
    n_checks++;
    if (Lost !== 1'b1 || ErrCount !== 8'd3) begin
      n_errors++;
      $display("FAIL lost_enter lost=%0b err=%0d required=1/3", Lost, ErrCount);
    end
    for (int i = 0; i < 2; i++) drive_edge(2'(i), 4'd0, 4'd12);
    n_checks++;
    if (ErrCount !== 8'd3 || Mismatch !== 1'b0 || Lost !== 1'b1) begin
      n_errors++;
      $display("FAIL lost_frozen err=%0d mm=%0b lost=%0b required=3/0/1", ErrCount, Mismatch, Lost);
    end
    drive_edge(2'b11, 4'd10, 4'd3);
    n_checks++;
    if (Lost !== 1'b0 || Expect !== 4'd10) begin
      n_errors++;
      $display("FAIL lost_reload lost=%0b expect=%0d required=0/10", Lost, Expect);
    end
  endtask

  task automatic test_saturation();
    int lost_seen = 0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic [3:0] wrong;
      wrong = 4'(m_exp) ^ 4'($urandom_range(1, 15));
      if (i % 2 == 0) drive_edge(2'b11, 4'($urandom_range(0, 15)), wrong);
      else            drive_edge(2'b00, 4'd0, wrong);
      if (Lost !== 1'b0) lost_seen++;
    end
    n_checks++;
    if (lost_seen != 0) begin
      n_errors++;
      $display("FAIL sat_lost lost_edges=%0d required=0", lost_seen);
    end
    n_checks++;
    if (ErrCount !== 8'd255) begin
      n_errors++;
      $display("FAIL sat_errcount actual=%0d required=255", ErrCount);
    end
  endtask

  task automatic test_reset_in_lost();
    do_reset();
    drive_edge(2'b00, 4'd0, 4'd8);
    for (int i = 0; i < 3; i++) drive_edge(2'b01, 4'd0, 4'd15);
    n_checks++;
    if (Lost !== 1'b1) begin
      n_errors++;
      $display("FAIL rstlost_pre lost=%0b required=1", Lost);
    end
    Reset = 1'b0;
    drive_edge(2'b01, 4'd0, 4'd15);
    Reset = 1'b1;
    n_checks++;
    if (Lost !== 1'b0 || ErrCount !== 8'd0 || Expect !== 4'd0 || Captured !== 1'b0) begin
      n_errors++;
      $display("FAIL rstlost_post lost=%0b err=%0d expect=%0d capt=%0b required=0/0/0/0", Lost, ErrCount, Expect, Captured);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] o;
      Reset = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      o = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'(m_exp);
      drive_edge(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), o);
      n_checks++;
      if (Expect !== 4'(m_exp) || Mismatch !== m_mm || Lost !== m_lost || ErrCount !== 8'(m_err)) begin
        n_errors++;
        $display("FAIL rand_core i=%0d exp=%0d/%0d mm=%0b/%0b lost=%0b/%0b err=%0d/%0d (actual/required)",
                 i, Expect, m_exp, Mismatch, m_mm, Lost, m_lost, ErrCount, m_err);
      end
      n_checks++;
      if (FirstErrCycle !== 16'(m_fcyc) || FirstErrExp !== 4'(m_fexp) ||
          FirstErrAct !== 4'(m_fact) || Captured !== m_capt) begin
        n_errors++;
        $display("FAIL rand_capture i=%0d cyc=%0d/%0d exp=%0d/%0d act=%0d/%0d capt=%0b/%0b (actual/required)",
                 i, FirstErrCycle, m_fcyc, FirstErrExp, m_fexp, FirstErrAct, m_fact, Captured, m_capt);
      end
    end
    Reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_single_miss();
    test_lost();
    test_saturation();
    test_reset_in_lost();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
